seq_mult_ctrl: RTL and testbench
================================

Name: seq_mult_ctrl

Overview:
- Multi-cycle unsigned shift-add multiplier controller for the CPU datapath.
- Sits directly around the N-bit ripple-carry adder.
  - Drives the adder's operand and carry-in inputs.
  - Consumes its sum and carry-out every iteration.
- Produces a 2N-bit product after N iterations, with a start/busy/done handshake to the issuing stage.
- Contains no adder of its own; all addition goes through the external adder ports.

Parameters:
- N, 16, operand width in bits; must match the attached adder width; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request to begin a multiply; sampled only in IDLE or DONE.
- multiplicand  input  N  operand A; captured on an accepted start.
- multiplier  input  N  operand B; captured on an accepted start.
- busy  output  1  high while iterating (RUN state).
- done  output  1  one-cycle pulse when the product becomes valid.
- product  output  2N  result; held stable from done until the next accepted start.
- add_a  output  N  to adder input1: upper accumulator.
- add_b  output  N  to adder input2: multiplicand or zero.
- add_cin  output  1  to adder cin; always 0.
- add_sum  input  N  from adder sum; combinational from add_a/add_b/add_cin.
- add_cout  input  1  from adder cout.

Behaviour:
- All state changes occur on the rising edge of clk. rst has priority over every other input.
- Reset values:
  - State = IDLE.
  - busy = 0, done = 0, product = 0.
  - Internal registers = 0: mcand (N), acc_hi (N), acc_lo (N), cnt (clog2(N+1) bits).
- Adder drive:
  - In RUN: add_a = acc_hi; add_b = acc_lo[0] ? mcand : 0; add_cin = 0.
  - In IDLE and DONE: add_a = 0, add_b = 0, add_cin = 0.
  - The adder path is purely combinational; the result is registered in the same cycle.
- State IDLE:
  - On start = 1: mcand <= multiplicand; acc_lo <= multiplier; acc_hi <= 0; cnt <= N; go to RUN.
  - Otherwise remain in IDLE.
- State RUN (busy = 1), one iteration per cycle:
  - acc_hi <= {add_cout, add_sum[N-1:1]}.
  - acc_lo <= {add_sum[0], acc_lo[N-1:1]}.
  - cnt <= cnt - 1.
  - When cnt == 1 in this cycle, go to DONE next.
  - start is ignored in RUN; operands are not re-sampled.
- State DONE (busy = 0):
  - done = 1 for exactly this one cycle.
  - product = {acc_hi, acc_lo}; product is registered and updated on entry to DONE.
  - If start = 1 in DONE: accept as in IDLE and go to RUN next cycle (back-to-back, no idle bubble).
  - Otherwise go to IDLE; product holds its value.
- Latency:
  - start accepted at edge E0.
  - busy high for cycles E0+1 .. E0+N.
  - done and a valid product in cycle E0+N+1.
  - Total: N+1 cycles from start to done.
- Arithmetic:
  - Unsigned only.
  - No overflow is possible: the N-bit × N-bit product fits in 2N bits, and add_cout is retained as the new MSB of acc_hi.
- Operand change: multiplicand/multiplier may change freely after acceptance without affecting the result.
- Reset mid-operation: on rst in RUN or DONE, return to IDLE next edge; product, busy and done are cleared; no done pulse is generated.
- Zero operands: still take the full N iterations; no early termination.

Test Plan:
- Basic multiply, N = 16: start with multiplicand = 3, multiplier = 5.
  - busy high for 16 cycles.
  - done pulses on cycle 17 after start.
  - product = 0x0000000F.
- Max operands: 0xFFFF × 0xFFFF.
  - product = 0xFFFE0001.
  - add_cout observed = 1 on at least one iteration.
- Zero and identity:
  - 0x0000 × 0x1234 → product 0, done still at +17.
  - 0x1234 × 0x0001 → product 0x00001234.
- Start during RUN: pulse start with new operands (7, 9) at cycle 5 of 2 × 3.
  - Ignored; product = 6.
  - done pulses exactly once.
- Back-to-back: start held high through DONE with 0x00FF × 0x0100.
  - First product is presented for its full done cycle.
  - Next RUN begins immediately; second done at +17 with product 0x0000FF00.
- Reset mid-op: assert rst at cycle 8 of 0xABCD × 0x1111.
  - Next edge: IDLE, busy = 0, product = 0, no done pulse.
  - A subsequent 4 × 4 returns 16.

Source files
------------

// File: rtl/seq_mult_ctrl.sv
// Shift-add unsigned multiplier controller: sequences an external N-bit adder
// for N iterations and presents a registered 2N-bit product with a done pulse.
module seq_mult_ctrl #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic [N-1:0]   add_a,
  output logic [N-1:0]   add_b,
  output logic           add_cin,
  input  logic [N-1:0]   add_sum,
  input  logic           add_cout
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [N-1:0]     mcand_reg, mcand_next;
  logic [N-1:0]     acc_hi_reg, acc_hi_next;
  logic [N-1:0]     acc_lo_reg, acc_lo_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [2*N-1:0]   product_reg, product_next;

  logic [N-1:0]     mcand_gated;
  logic [N-1:0]     shift_hi, shift_lo;

  // Partial product: multiplicand where the current multiplier LSB is set.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_gate
      assign mcand_gated[gi] = mcand_reg[gi] & acc_lo_reg[0];
    end
  endgenerate

  // Carry-out becomes the new top bit, so the full 2N-bit result never overflows.
  assign shift_hi = {add_cout, add_sum[N-1:1]};
  assign shift_lo = {add_sum[0], acc_lo_reg[N-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      mcand_reg   <= '0;
      acc_hi_reg  <= '0;
      acc_lo_reg  <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else begin
      state_reg   <= state_next;
      mcand_reg   <= mcand_next;
      acc_hi_reg  <= acc_hi_next;
      acc_lo_reg  <= acc_lo_next;
      cnt_reg     <= cnt_next;
      product_reg <= product_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mcand_next   = mcand_reg;
    acc_hi_next  = acc_hi_reg;
    acc_lo_next  = acc_lo_reg;
    cnt_next     = cnt_reg;
    product_next = product_reg;
    busy         = 1'b0;
    done         = 1'b0;
    add_a        = '0;
    add_b        = '0;
    add_cin      = 1'b0;

    case (state_reg)
      IDLE, DONE: begin
        done = (state_reg == DONE);
        if (start) begin
          mcand_next  = multiplicand;
          acc_lo_next = multiplier;
          acc_hi_next = '0;
          cnt_next    = CNT_INIT;
          state_next  = RUN;
        end else begin
          state_next  = IDLE;
        end
      end
      RUN: begin
        busy        = 1'b1;
        add_a       = acc_hi_reg;
        add_b       = mcand_gated;
        acc_hi_next = shift_hi;
        acc_lo_next = shift_lo;
        cnt_next    = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          product_next = {shift_hi, shift_lo};
          state_next   = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign product = product_reg;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Scoreboard bench for seq_mult_ctrl: directed multiplies push expected
// product and done cycle; a negedge monitor checks every done pulse.
module tb_seq_mult_ctrl;
  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N-1:0]   multiplicand, multiplier;
  logic           busy, done;
  logic [2*N-1:0] product;
  logic [N-1:0]   add_a, add_b, add_sum;
  logic           add_cin, add_cout;

  typedef struct {
    logic [2*N-1:0] prod;
    int             cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   busy_cnt = 0;
  bit   cout_seen = 0;

  seq_mult_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // External ripple-carry adder stand-in
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: adder drive rules every cycle, scoreboard compare on each done.
  always @(negedge clk) begin
    if (!rst) begin
      check("add_cin_zero", 64'(add_cin), 64'd0);
      if (!busy) check("idle_adder_zero", {32'd0, add_a, add_b}, 64'd0);
      if (busy) begin
        busy_cnt++;
        if (add_cout) cout_seen = 1'b1;
      end else if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("product", 64'(product), 64'(e.prod));
          check("done_cycle", 64'(cyc), 64'(e.cyc));
          check("busy_cycles", 64'(busy_cnt), 64'(N));
          $display("txn: product=0x%08h done at cycle %0d busy %0d", product, cyc, busy_cnt);
        end
        busy_cnt = 0;
      end else begin
        busy_cnt = 0;
      end
    end
  end

  // Called just after a rising edge; the next edge accepts the start.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [2*N-1:0] exp_prod, input bit push);
    exp_t e;
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    if (push) begin
      e.prod = exp_prod;
      e.cyc  = cyc + 1 + N;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    start        = 1'b0;
    multiplicand = 16'hDEAD;
    multiplier   = 16'hBEEF;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 4 * N; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(16'd3, 16'd5, 32'h0000000F, 1'b1);
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    check("product_hold", 64'(product), 64'h0F);

    cout_seen = 1'b0;
    issue(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1);
    wait_done();
    check("cout_seen", 64'(cout_seen), 64'd1);

    issue(16'h0000, 16'h1234, 32'h00000000, 1'b1);
    wait_done();
    issue(16'h1234, 16'h0001, 32'h00001234, 1'b1);
    wait_done();

    // A start pulse mid-run must be ignored
    issue(16'd2, 16'd3, 32'd6, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; multiplicand = 16'd7; multiplier = 16'd9;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    repeat (4) @(posedge clk);
    #1;

    // Back-to-back: start held through the first DONE cycle
    begin
      exp_t e;
      int   c;
      c = cyc;
      start = 1'b1; multiplicand = 16'h00FF; multiplier = 16'h0100;
      e.prod = 32'h0000FF00; e.cyc = c + 1 + N;     exp_q.push_back(e);
      e.prod = 32'h0000FF00; e.cyc = c + 2 * N + 2; exp_q.push_back(e);
      repeat (N + 2) @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b_busy_after_accept", 64'(busy), 64'd1);
      wait_done();
    end

    // Reset in the middle of a run clears everything, no done pulse
    issue(16'hABCD, 16'h1111, 32'd0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_product", 64'(product), 64'd0);
    rst = 1'b0;
    repeat (N + 4) @(posedge clk);
    #1;
    check("midrst_no_done_product", 64'(product), 64'd0);

    issue(16'd4, 16'd4, 32'd16, 1'b1);
    wait_done();

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
